// File: rtl/writeback_queue_if.sv
// Write-back queue bus: producer inputs, register-file write port,
// bypass lookups and occupancy.
interface writeback_queue_if #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic              Mem_Valid;
   logic [ADDR_W-1:0] Mem_Reg;
   logic [DATA_W-1:0] Mem_Data;
   logic              ALU_Valid;
   logic [ADDR_W-1:0] ALU_Reg;
   logic [DATA_W-1:0] ALU_Data;
   logic              Ready;
   logic              Reg_Write;
   logic [ADDR_W-1:0] Write_Reg;
   logic [DATA_W-1:0] Write_Data;
   logic [ADDR_W-1:0] Lookup_Reg_1;
   logic [ADDR_W-1:0] Lookup_Reg_2;
   logic              Lookup_Hit_1;
   logic              Lookup_Hit_2;
   logic [DATA_W-1:0] Lookup_Data_1;
   logic [DATA_W-1:0] Lookup_Data_2;
   logic [CW-1:0]     Count;

   modport master (
      output Mem_Valid, Mem_Reg, Mem_Data,
      output ALU_Valid, ALU_Reg, ALU_Data,
      output Lookup_Reg_1, Lookup_Reg_2,
      input  Ready, Reg_Write, Write_Reg, Write_Data,
      input  Lookup_Hit_1, Lookup_Hit_2,
      input  Lookup_Data_1, Lookup_Data_2, Count
   );

   modport slave (
      input  Mem_Valid, Mem_Reg, Mem_Data,
      input  ALU_Valid, ALU_Reg, ALU_Data,
      input  Lookup_Reg_1, Lookup_Reg_2,
      output Ready, Reg_Write, Write_Reg, Write_Data,
      output Lookup_Hit_1, Lookup_Hit_2,
      output Lookup_Data_1, Lookup_Data_2, Count
   );
endinterface

// File: rtl/writeback_queue.sv
// In-order write-back buffer: two results in per cycle, one registered
// register-file write out per cycle, with youngest-wins bypass lookup.
module writeback_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic Clock,
   input  logic Reset,
   writeback_queue_if.slave bus
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [ADDR_W-1:0] r_q_reg  [DEPTH];
   logic [DATA_W-1:0] r_q_data [DEPTH];
   logic [PW-1:0]     r_head;
   logic [PW-1:0]     r_tail;
   logic [CW-1:0]     r_count;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_reg;
   logic [DATA_W-1:0] r_wr_data;

   logic              w_ready;
   logic              w_mem_en;
   logic              w_alu_en;
   logic              w_deq;
   logic [PW-1:0]     w_alu_slot;
   logic [DATA_W:0]   w_look_1;
   logic [DATA_W:0]   w_look_2;

   assign w_ready    = (r_count <= CW'(DEPTH - 2));
   assign w_mem_en   = w_ready && bus.Mem_Valid && (bus.Mem_Reg != '0);
   assign w_alu_en   = w_ready && bus.ALU_Valid && (bus.ALU_Reg != '0);
   assign w_deq      = (r_count != '0);
   assign w_alu_slot = r_tail + PW'(w_mem_en);

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         r_head    <= '0;
         r_tail    <= '0;
         r_count   <= '0;
         r_wr_en   <= 1'b0;
         r_wr_reg  <= '0;
         r_wr_data <= '0;
      end else begin
         r_tail  <= r_tail + PW'(w_mem_en) + PW'(w_alu_en);
         r_count <= r_count + CW'(w_mem_en) + CW'(w_alu_en) - CW'(w_deq);
         r_wr_en <= w_deq;
         if (w_deq) begin
            r_head    <= r_head + PW'(1);
            r_wr_reg  <= r_q_reg[r_head];
            r_wr_data <= r_q_data[r_head];
         end
      end
   end

   // Payload storage needs no reset; validity comes from r_count.
   always_ff @(posedge Clock) begin
      if (w_mem_en) begin
         r_q_reg[r_tail]  <= bus.Mem_Reg;
         r_q_data[r_tail] <= bus.Mem_Data;
      end
      if (w_alu_en) begin
         r_q_reg[w_alu_slot]  <= bus.ALU_Reg;
         r_q_data[w_alu_slot] <= bus.ALU_Data;
      end
   end

   // Scan oldest to youngest so the last match left standing wins.
   function automatic logic [DATA_W:0] f_lookup(
      input logic [ADDR_W-1:0] idx
   );
      logic [DATA_W:0] res;
      logic [PW-1:0]   p;
      res = '0;
      if (idx != '0) begin
         if (r_wr_en && (r_wr_reg == idx))
            res = {1'b1, r_wr_data};
         for (int i = 0; i < DEPTH; i++) begin
            p = r_head + PW'(i);
            if ((CW'(i) < r_count) && (r_q_reg[p] == idx))
               res = {1'b1, r_q_data[p]};
         end
      end
      return res;
   endfunction

   always_comb begin
      w_look_1 = '0;
      w_look_2 = '0;
      w_look_1 = f_lookup(bus.Lookup_Reg_1);
      w_look_2 = f_lookup(bus.Lookup_Reg_2);
   end

   assign bus.Ready         = w_ready;
   assign bus.Reg_Write     = r_wr_en;
   assign bus.Write_Reg     = r_wr_reg;
   assign bus.Write_Data    = r_wr_data;
   assign bus.Count         = r_count;
   assign bus.Lookup_Hit_1  = w_look_1[DATA_W];
   assign bus.Lookup_Data_1 = w_look_1[DATA_W-1:0];
   assign bus.Lookup_Hit_2  = w_look_2[DATA_W];
   assign bus.Lookup_Data_2 = w_look_2[DATA_W-1:0];
endmodule
